// File: rtl/sal_cmd_arbiter.sv
// Rank-level DDR2 command arbiter: class-priority plus round-robin grant selection,
// inter-bank timing enforcement (tRRD/tFAW/tCCD/tWTR/tRTW) and a registered DFI command.
module sal_cmd_arbiter #(
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned BA_WIDTH   = 3,
    parameter int unsigned RA_WIDTH   = 14,
    parameter int unsigned CA_WIDTH   = 10,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned CNTR_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BANKS-1:0]           act_req_i,
    input  logic [NUM_BANKS-1:0]           rd_req_i,
    input  logic [NUM_BANKS-1:0]           wr_req_i,
    input  logic [NUM_BANKS-1:0]           pre_req_i,
    input  logic [NUM_BANKS-1:0]           ref_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i,
    output logic [NUM_BANKS-1:0]           act_gnt_o,
    output logic [NUM_BANKS-1:0]           rd_gnt_o,
    output logic [NUM_BANKS-1:0]           wr_gnt_o,
    output logic [NUM_BANKS-1:0]           pre_gnt_o,
    output logic [NUM_BANKS-1:0]           ref_gnt_o,
    input  logic [CNTR_WIDTH-1:0]          t_rrd_m1,
    input  logic [CNTR_WIDTH-1:0]          t_faw_m1,
    input  logic [CNTR_WIDTH-1:0]          t_ccd_m1,
    input  logic [CNTR_WIDTH-1:0]          t_wtr_m1,
    input  logic [CNTR_WIDTH-1:0]          t_rtw_m1,
    output logic                           cs_n_o,
    output logic                           ras_n_o,
    output logic                           cas_n_o,
    output logic                           we_n_o,
    output logic [BA_WIDTH-1:0]            ba_o,
    output logic [RA_WIDTH-1:0]            addr_o,
    output logic                           rd_issue_o,
    output logic [ID_WIDTH-1:0]            rd_id_o
);

    typedef enum logic [2:0] {CMD_NONE, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF} cmd_e;

    logic [BA_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNTR_WIDTH-1:0]      rrd_cnt_q, rrd_cnt_d;
    logic [CNTR_WIDTH-1:0]      ccd_cnt_q, ccd_cnt_d;
    logic [CNTR_WIDTH-1:0]      wtr_cnt_q, wtr_cnt_d;
    logic [CNTR_WIDTH-1:0]      rtw_cnt_q, rtw_cnt_d;
    logic [3:0][CNTR_WIDTH-1:0] faw_cnt_q, faw_cnt_d;

    logic                       cs_n_q, cs_n_d, ras_n_q, ras_n_d;
    logic                       cas_n_q, cas_n_d, we_n_q, we_n_d;
    logic [BA_WIDTH-1:0]        ba_q, ba_d;
    logic [RA_WIDTH-1:0]        addr_q, addr_d;
    logic                       rd_issue_q, rd_issue_d;
    logic [ID_WIDTH-1:0]        rd_id_q, rd_id_d;

    cmd_e                       cmd;
    logic [BA_WIDTH-1:0]        sel;
    logic [BA_WIDTH:0]          col_pick, act_pick, pre_pick;
    logic                       act_ok, rd_ok, wr_ok, faw_free, faw_found;
    logic [NUM_BANKS-1:0]       col_vec, onehot;
    logic [RA_WIDTH-1:0]        sel_ra;
    logic [CA_WIDTH-1:0]        sel_ca;
    logic [ID_WIDTH-1:0]        sel_id;

    function automatic logic [CNTR_WIDTH-1:0] dec_sat(input logic [CNTR_WIDTH-1:0] c);
        return (c == '0) ? '0 : c - CNTR_WIDTH'(1);
    endfunction

    // Returns {found, bank}: first set bit of vec searching upward from ptr, wrapping.
    function automatic logic [BA_WIDTH:0] rr_pick(input logic [NUM_BANKS-1:0] vec,
                                                  input logic [BA_WIDTH-1:0]  ptr);
        logic                found;
        logic [BA_WIDTH-1:0] idx, pick;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            idx = ptr + BA_WIDTH'(i);
            if (!found && vec[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    always_comb begin
        faw_free = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (faw_cnt_q[k] == '0) faw_free = 1'b1;
        end
        act_ok   = (rrd_cnt_q == '0) && faw_free;
        rd_ok    = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
        wr_ok    = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
        col_vec  = (rd_req_i & {NUM_BANKS{rd_ok}}) | (wr_req_i & {NUM_BANKS{wr_ok}});
        col_pick = rr_pick(col_vec, rr_ptr_q);
        act_pick = rr_pick(act_req_i & {NUM_BANKS{act_ok}}, rr_ptr_q);
        pre_pick = rr_pick(pre_req_i, rr_ptr_q);

        cmd = CMD_NONE;
        sel = '0;
        if (!rst_n) begin
            cmd = CMD_NONE;
        end else if (&ref_req_i) begin
            cmd = CMD_REF;
        end else if (col_pick[BA_WIDTH]) begin
            sel = col_pick[BA_WIDTH-1:0];
            cmd = (rd_req_i[sel] && rd_ok) ? CMD_RD : CMD_WR;
        end else if (act_pick[BA_WIDTH]) begin
            sel = act_pick[BA_WIDTH-1:0];
            cmd = CMD_ACT;
        end else if (pre_pick[BA_WIDTH]) begin
            sel = pre_pick[BA_WIDTH-1:0];
            cmd = CMD_PRE;
        end

        onehot    = NUM_BANKS'(1) << sel;
        act_gnt_o = (cmd == CMD_ACT) ? onehot : '0;
        rd_gnt_o  = (cmd == CMD_RD)  ? onehot : '0;
        wr_gnt_o  = (cmd == CMD_WR)  ? onehot : '0;
        pre_gnt_o = (cmd == CMD_PRE) ? onehot : '0;
        ref_gnt_o = (cmd == CMD_REF) ? '1     : '0;

        sel_ra = ra_i[sel*RA_WIDTH +: RA_WIDTH];
        sel_ca = ca_i[sel*CA_WIDTH +: CA_WIDTH];
        sel_id = id_i[sel*ID_WIDTH +: ID_WIDTH];
    end

    // Counters: a load on the triggering grant wins over the per-cycle decrement.
    always_comb begin
        rrd_cnt_d = (cmd == CMD_ACT) ? t_rrd_m1 : dec_sat(rrd_cnt_q);
        ccd_cnt_d = (cmd == CMD_RD || cmd == CMD_WR) ? t_ccd_m1 : dec_sat(ccd_cnt_q);
        wtr_cnt_d = (cmd == CMD_WR) ? t_wtr_m1 : dec_sat(wtr_cnt_q);
        rtw_cnt_d = (cmd == CMD_RD) ? t_rtw_m1 : dec_sat(rtw_cnt_q);
        faw_found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            faw_cnt_d[k] = dec_sat(faw_cnt_q[k]);
            if (cmd == CMD_ACT && !faw_found && faw_cnt_q[k] == '0) begin
                faw_cnt_d[k] = t_faw_m1;
                faw_found    = 1'b1;
            end
        end
        rr_ptr_d = (cmd == CMD_NONE || cmd == CMD_REF) ? rr_ptr_q : sel + BA_WIDTH'(1);
    end

    always_comb begin
        cs_n_d     = 1'b1;
        ras_n_d    = 1'b1;
        cas_n_d    = 1'b1;
        we_n_d     = 1'b1;
        ba_d       = '0;
        addr_d     = '0;
        rd_issue_d = 1'b0;
        rd_id_d    = '0;
        case (cmd)
            CMD_ACT: begin
                {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0011;
                ba_d   = sel;
                addr_d = sel_ra;
            end
            CMD_RD: begin
                {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0101;
                ba_d       = sel;
                addr_d     = RA_WIDTH'(sel_ca);
                rd_issue_d = 1'b1;
                rd_id_d    = sel_id;
            end
            CMD_WR: begin
                {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0100;
                ba_d   = sel;
                addr_d = RA_WIDTH'(sel_ca);
            end
            CMD_PRE: begin
                {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0010;
                ba_d = sel;
            end
            CMD_REF: begin
                {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0001;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rrd_cnt_q  <= '0;
            ccd_cnt_q  <= '0;
            wtr_cnt_q  <= '0;
            rtw_cnt_q  <= '0;
            faw_cnt_q  <= '0;
            cs_n_q     <= 1'b1;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            ba_q       <= '0;
            addr_q     <= '0;
            rd_issue_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rrd_cnt_q  <= rrd_cnt_d;
            ccd_cnt_q  <= ccd_cnt_d;
            wtr_cnt_q  <= wtr_cnt_d;
            rtw_cnt_q  <= rtw_cnt_d;
            faw_cnt_q  <= faw_cnt_d;
            cs_n_q     <= cs_n_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            rd_issue_q <= rd_issue_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign cs_n_o     = cs_n_q;
    assign ras_n_o    = ras_n_q;
    assign cas_n_o    = cas_n_q;
    assign we_n_o     = we_n_q;
    assign ba_o       = ba_q;
    assign addr_o     = addr_q;
    assign rd_issue_o = rd_issue_q;
    assign rd_id_o    = rd_id_q;

endmodule
